// File: rtl/md_pkg.sv
// md_pkg: shared types and defaults for the multiply/divide unit.
// Holds MDOp encodings, cycle-count defaults and the counter width.
package md_pkg;

    typedef enum logic [2:0] {
        MD_NONE  = 3'd0,
        MD_MULT  = 3'd1,
        MD_MULTU = 3'd2,
        MD_DIV   = 3'd3,
        MD_DIVU  = 3'd4,
        MD_MTHI  = 3'd5,
        MD_MTLO  = 3'd6,
        MD_RSVD  = 3'd7
    } mdOp_e;

    localparam int MULT_CYCLES_DEF = 5;
    localparam int DIV_CYCLES_DEF  = 10;
    localparam int CNT_W           = 8;

    function automatic logic isLongOp(input logic [2:0] op);
        return (op == MD_MULT) || (op == MD_MULTU) ||
               (op == MD_DIV)  || (op == MD_DIVU);
    endfunction

endpackage

// File: rtl/md_if.sv
// md_if: EX-stage bundle between the pipeline and md_unit.
// Operands/op/mdD flow in; HI/LO/Busy/Start/MdStall flow out.
interface md_if;
    logic [31:0] A;
    logic [31:0] B;
    logic [2:0]  MDOpE;
    logic        mdD;
    logic [31:0] HI;
    logic [31:0] LO;
    logic        Busy;
    logic        Start;
    logic        MdStall;

    modport master (
        output A, B, MDOpE, mdD,
        input  HI, LO, Busy, Start, MdStall
    );

    modport slave (
        input  A, B, MDOpE, mdD,
        output HI, LO, Busy, Start, MdStall
    );
endinterface

// File: rtl/md_divider.sv
// md_divider: combinational 32-bit signed/unsigned divide.
// Ports: a, b, isSigned in; quot, rem, divZero out.
module md_divider (
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        isSigned,
    output logic [31:0] quot,
    output logic [31:0] rem,
    output logic        divZero
);
    logic        negA;
    logic        negB;
    logic [31:0] magA;
    logic [31:0] magB;
    logic [31:0] qMag;
    logic [31:0] rMag;

    // Divide magnitudes unsigned, then restore signs. This keeps
    // 0x80000000 / -1 well defined (quotient wraps to 0x80000000).
    always_comb begin
        negA    = isSigned & a[31];
        negB    = isSigned & b[31];
        magA    = negA ? (~a + 32'd1) : a;
        magB    = negB ? (~b + 32'd1) : b;
        divZero = (b == 32'd0);
        qMag    = 32'd0;
        rMag    = 32'd0;
        if (!divZero) begin
            qMag = magA / magB;
            rMag = magA % magB;
        end
        quot = (negA ^ negB) ? (~qMag + 32'd1) : qMag;
        rem  = negA ? (~rMag + 32'd1) : rMag;
    end
endmodule

// File: rtl/md_unit.sv
// md_unit: EX-stage multiply/divide unit owning HI/LO.
// Ports: clk, reset (async active-low), io (md_if.slave).
module md_unit
    import md_pkg::*;
#(
    parameter int MULT_CYCLES = MULT_CYCLES_DEF,
    parameter int DIV_CYCLES  = DIV_CYCLES_DEF
) (
    input logic clk,
    input logic reset,
    md_if.slave io
);
    logic [CNT_W-1:0] count;
    logic [31:0]      pendHi;
    logic [31:0]      pendLo;
    logic             pendWrite;
    logic [63:0]      prodS;
    logic [63:0]      prodU;
    logic [31:0]      quot;
    logic [31:0]      rem;
    logic             divZero;
    logic             isDivS;

    assign io.Start   = isLongOp(io.MDOpE) & ~io.Busy;
    assign io.MdStall = io.mdD & (io.Start | io.Busy);

    // Low 64 bits of a sign-extended product equal the signed product.
    assign prodS = {{32{io.A[31]}}, io.A} * {{32{io.B[31]}}, io.B};
    assign prodU = {32'd0, io.A} * {32'd0, io.B};
    assign isDivS = (io.MDOpE == MD_DIV);

    md_divider u_div (
        .a       (io.A),
        .b       (io.B),
        .isSigned(isDivS),
        .quot    (quot),
        .rem     (rem),
        .divZero (divZero)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            io.HI     <= 32'd0;
            io.LO     <= 32'd0;
            io.Busy   <= 1'b0;
            count     <= '0;
            pendHi    <= 32'd0;
            pendLo    <= 32'd0;
            pendWrite <= 1'b0;
        end else if (io.Busy) begin
            // Any op arriving now is dropped; just count down.
            count <= count - 1'b1;
            if (count == CNT_W'(1)) begin
                io.Busy <= 1'b0;
                if (pendWrite) begin
                    io.HI <= pendHi;
                    io.LO <= pendLo;
                end
            end
        end else begin
            case (io.MDOpE)
                MD_MULT: begin
                    {pendHi, pendLo} <= prodS;
                    pendWrite <= 1'b1;
                    count     <= CNT_W'(MULT_CYCLES);
                    io.Busy   <= 1'b1;
                end
                MD_MULTU: begin
                    {pendHi, pendLo} <= prodU;
                    pendWrite <= 1'b1;
                    count     <= CNT_W'(MULT_CYCLES);
                    io.Busy   <= 1'b1;
                end
                MD_DIV, MD_DIVU: begin
                    pendHi    <= rem;
                    pendLo    <= quot;
                    // B=0 still burns the full latency but keeps HI/LO.
                    pendWrite <= ~divZero;
                    count     <= CNT_W'(DIV_CYCLES);
                    io.Busy   <= 1'b1;
                end
                MD_MTHI: io.HI <= io.A;
                MD_MTLO: io.LO <= io.A;
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_md_unit.sv
// tb_md_unit: scoreboard bench for md_unit.
// Expected HI/LO pushed at issue, popped when Busy falls.
module tb_md_unit;
    import md_pkg::*;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        int          cyc;
    } exp_t;

    logic clk;
    logic reset;
    int   checks;
    int   failures;
    exp_t sb[$];

    md_if bus ();

    md_unit #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk  (clk),
        .reset(reset),
        .io   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic issue(input logic [2:0] op,
                         input logic [31:0] a,
                         input logic [31:0] b);
        @(negedge clk);
        bus.MDOpE = op;
        bus.A     = a;
        bus.B     = b;
        @(posedge clk);
        #1;
        bus.MDOpE = MD_NONE;
    endtask

    task automatic waitIdle(output int n);
        n = 0;
        while (bus.Busy && n < 50) begin
            @(posedge clk);
            #1;
            n++;
        end
    endtask

    task automatic test_reset;
        reset = 1'b0;
        bus.A = 0; bus.B = 0; bus.MDOpE = MD_NONE; bus.mdD = 0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if (bus.HI !== 32'd0 || bus.LO !== 32'd0 || bus.Busy !== 1'b0) begin
            failures++;
            $display("FAIL reset: HI=%h LO=%h Busy=%b want 0/0/0",
                     bus.HI, bus.LO, bus.Busy);
        end
    endtask

    task automatic test_mult;
        exp_t e;
        int   n;
        sb.push_back('{32'hFFFFFFFF, 32'hFFFFFFFE, 5});
        issue(MD_MULT, 32'hFFFFFFFF, 32'd2);
        waitIdle(n);
        e = sb.pop_front();
        checks++;
        if (n !== e.cyc) begin
            failures++;
            $display("FAIL mult_busy: got %0d want %0d", n, e.cyc);
        end
        checks++;
        if (bus.HI !== e.hi || bus.LO !== e.lo) begin
            failures++;
            $display("FAIL mult: HI=%h LO=%h want %h %h",
                     bus.HI, bus.LO, e.hi, e.lo);
        end
    endtask

    task automatic test_multu;
        exp_t e;
        int   n;
        sb.push_back('{32'h00000001, 32'hFFFFFFFE, 5});
        issue(MD_MULTU, 32'hFFFFFFFF, 32'd2);
        waitIdle(n);
        e = sb.pop_front();
        checks++;
        if (n !== e.cyc || bus.HI !== e.hi || bus.LO !== e.lo) begin
            failures++;
            $display("FAIL multu: n=%0d HI=%h LO=%h want %0d %h %h",
                     n, bus.HI, bus.LO, e.cyc, e.hi, e.lo);
        end
    endtask

    task automatic test_div;
        exp_t e;
        int   n;
        sb.push_back('{32'hFFFFFFFF, 32'hFFFFFFFD, 10});
        sb.push_back('{32'h00000001, 32'h7FFFFFFC, 10});
        sb.push_back('{32'h00000000, 32'h80000000, 10});
        sb.push_back('{32'h00000001, 32'hFFFFFFFD, 10});
        issue(MD_DIV, 32'hFFFFFFF9, 32'd2);
        waitIdle(n);
        e = sb.pop_front();
        checks++;
        if (n !== e.cyc || bus.HI !== e.hi || bus.LO !== e.lo) begin
            failures++;
            $display("FAIL div: n=%0d HI=%h LO=%h want %0d %h %h",
                     n, bus.HI, bus.LO, e.cyc, e.hi, e.lo);
        end
        issue(MD_DIVU, 32'hFFFFFFF9, 32'd2);
        waitIdle(n);
        e = sb.pop_front();
        checks++;
        if (n !== e.cyc || bus.HI !== e.hi || bus.LO !== e.lo) begin
            failures++;
            $display("FAIL divu: n=%0d HI=%h LO=%h want %0d %h %h",
                     n, bus.HI, bus.LO, e.cyc, e.hi, e.lo);
        end
        issue(MD_DIV, 32'h80000000, 32'hFFFFFFFF);
        waitIdle(n);
        e = sb.pop_front();
        checks++;
        if (bus.HI !== e.hi || bus.LO !== e.lo) begin
            failures++;
            $display("FAIL div_ovf: HI=%h LO=%h want %h %h",
                     bus.HI, bus.LO, e.hi, e.lo);
        end
        // 7 / -2: quotient -3, remainder +1 (sign of dividend)
        issue(MD_DIV, 32'd7, 32'hFFFFFFFE);
        waitIdle(n);
        e = sb.pop_front();
        checks++;
        if (bus.HI !== e.hi || bus.LO !== e.lo) begin
            failures++;
            $display("FAIL div_negb: HI=%h LO=%h want %h %h",
                     bus.HI, bus.LO, e.hi, e.lo);
        end
    endtask

    task automatic test_divzero;
        exp_t e;
        int   n;
        issue(MD_MTHI, 32'h12345678, 32'd0);
        issue(MD_MTLO, 32'h9ABCDEF0, 32'd0);
        checks++;
        if (bus.HI !== 32'h12345678 || bus.LO !== 32'h9ABCDEF0) begin
            failures++;
            $display("FAIL preset: HI=%h LO=%h want 12345678 9abcdef0",
                     bus.HI, bus.LO);
        end
        sb.push_back('{32'h12345678, 32'h9ABCDEF0, 10});
        issue(MD_DIVU, 32'd7, 32'd0);
        waitIdle(n);
        e = sb.pop_front();
        checks++;
        if (n !== e.cyc || bus.HI !== e.hi || bus.LO !== e.lo) begin
            failures++;
            $display("FAIL divzero: n=%0d HI=%h LO=%h want %0d %h %h",
                     n, bus.HI, bus.LO, e.cyc, e.hi, e.lo);
        end
    endtask

    task automatic test_mthi;
        issue(MD_MTHI, 32'hCAFEBABE, 32'd0);
        checks++;
        if (bus.HI !== 32'hCAFEBABE || bus.Busy !== 1'b0 ||
            bus.LO !== 32'h9ABCDEF0) begin
            failures++;
            $display("FAIL mthi: HI=%h LO=%h Busy=%b want cafebabe 9abcdef0 0",
                     bus.HI, bus.LO, bus.Busy);
        end
    endtask

    task automatic test_mthi_busy;
        exp_t e;
        int   n;
        sb.push_back('{32'd2, 32'd6, 10});
        issue(MD_DIVU, 32'd20, 32'd3);
        @(negedge clk);
        bus.MDOpE = MD_MTHI;
        bus.A     = 32'hDEADBEEF;
        bus.B     = 32'd0;
        #1;
        checks++;
        if (bus.Start !== 1'b0) begin
            failures++;
            $display("FAIL start_busy: got %b want 0", bus.Start);
        end
        @(posedge clk);
        #1;
        bus.MDOpE = MD_MULT;
        bus.A     = 32'd3;
        bus.B     = 32'd3;
        @(posedge clk);
        #1;
        bus.MDOpE = MD_NONE;
        checks++;
        if (bus.HI !== 32'hCAFEBABE) begin
            failures++;
            $display("FAIL mthi_busy: HI=%h want cafebabe", bus.HI);
        end
        waitIdle(n);
        e = sb.pop_front();
        checks++;
        if (n !== 8 || bus.HI !== e.hi || bus.LO !== e.lo) begin
            failures++;
            $display("FAIL busy_ignore: n=%0d HI=%h LO=%h want 8 %h %h",
                     n, bus.HI, bus.LO, e.hi, e.lo);
        end
    endtask

    task automatic test_stall;
        exp_t e;
        int   n;
        int   bad;
        bad = 0;
        sb.push_back('{32'd0, 32'd12, 5});
        @(negedge clk);
        bus.mdD   = 1'b1;
        bus.MDOpE = MD_MULT;
        bus.A     = 32'd3;
        bus.B     = 32'd4;
        #1;
        checks++;
        if (bus.MdStall !== 1'b1 || bus.Start !== 1'b1) begin
            failures++;
            $display("FAIL stall_start: MdStall=%b Start=%b want 1 1",
                     bus.MdStall, bus.Start);
        end
        @(posedge clk);
        #1;
        bus.MDOpE = MD_NONE;
        for (int i = 0; i < 5; i++) begin
            if (bus.MdStall !== 1'b1) bad++;
            @(posedge clk);
            #1;
        end
        checks++;
        if (bad !== 0) begin
            failures++;
            $display("FAIL stall_busy: %0d low cycles want 0", bad);
        end
        checks++;
        if (bus.MdStall !== 1'b0 || bus.Busy !== 1'b0) begin
            failures++;
            $display("FAIL stall_idle: MdStall=%b Busy=%b want 0 0",
                     bus.MdStall, bus.Busy);
        end
        waitIdle(n);
        e = sb.pop_front();
        checks++;
        if (bus.HI !== e.hi || bus.LO !== e.lo) begin
            failures++;
            $display("FAIL stall_mult: HI=%h LO=%h want %h %h",
                     bus.HI, bus.LO, e.hi, e.lo);
        end
        bus.mdD = 1'b0;
    endtask

    task automatic test_reset_midop;
        int n;
        issue(MD_DIVU, 32'd100, 32'd7);
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        #1;
        checks++;
        if (bus.Busy !== 1'b0 || bus.HI !== 32'd0 || bus.LO !== 32'd0) begin
            failures++;
            $display("FAIL reset_mid: Busy=%b HI=%h LO=%h want 0 0 0",
                     bus.Busy, bus.HI, bus.LO);
        end
        @(negedge clk);
        reset = 1'b1;
        repeat (12) @(posedge clk);
        #1;
        waitIdle(n);
        checks++;
        if (bus.Busy !== 1'b0 || bus.HI !== 32'd0 || bus.LO !== 32'd0) begin
            failures++;
            $display("FAIL reset_nocommit: Busy=%b HI=%h LO=%h want 0 0 0",
                     bus.Busy, bus.HI, bus.LO);
        end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        test_reset();
        test_mult();
        test_multu();
        test_div();
        test_divzero();
        test_mthi();
        test_mthi_busy();
        test_stall();
        test_reset_midop();
        checks++;
        if (sb.size() !== 0) begin
            failures++;
            $display("FAIL scoreboard: %0d left want 0", sb.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
